clk_div_gen: RTL
================

# clk_div_gen

Synthesizable multi-channel clock generator that derives CH independent divided clocks from the single system clock `clk`. Each channel has a programmable period and high time, glitch-free start/stop, and shadowed configuration updates that take effect only on a period boundary. It replaces hand-written testbench clock loops and provides derived clocks and strobes for on-chip blocks and benches.

## Interface
- `CH`, 4: number of output channels (1–16).
- `CW`, 8: width of the period, high and phase counters.

- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `en`  in  CH: per-channel run request.
- `upd`  in  CH: per-channel one-cycle configuration-load strobe.
- `period`  in  CH*CW: channel i period P, in clk cycles, at slice [i*CW +: CW].
- `high`  in  CH*CW: channel i high time H, in clk cycles.
- `phase`  in  CH*CW: channel i start offset. Present only with `CLKGEN_PHASE_EN`.
- `clk_out`  out  CH: registered divided clocks.
- `tick`  out  CH: one-cycle pulse in every cycle where the channel counter is 0 and the channel is running.
- `pend`  out  CH: a shadow configuration is waiting for the next boundary.
- `busy`  out  CH: channel is in RUN or STOP.

## Operation
- Per-channel registers:
  - active configuration Pa/Ha, reset to 2/1;
  - shadow configuration Ps/Hs;
  - `pend`;
  - counter `cnt` (CW bits);
  - state, one of IDLE/RUN/STOP.
- Clamping is applied at capture:
  - P<2 becomes 2;
  - H=0 becomes 1;
  - H≥P becomes P-1.
  - Duty is therefore never 0% or 100%.
- `upd[i]`:
  - In IDLE: period/high are written straight into Pa/Ha. `pend` stays 0.
  - Otherwise: written into Ps/Hs and `pend`=1. A later `upd` before the boundary overwrites the shadow (last write wins).
- Boundary = cycle where state is RUN or STOP and `cnt`==Pa-1.
  - At a boundary with `pend`=1: Pa/Ha←Ps/Hs and `pend`←0.
  - If `upd` coincides with the boundary: the old shadow is applied, the new value is captured, and `pend` stays 1.
- Registered outputs:
  - `clk_out` = (state≠IDLE) && (`cnt` < Ha).
  - `tick` = (state≠IDLE) && (`cnt`==0).
- Counter: `cnt` increments each cycle in RUN/STOP and wraps from Pa-1 to 0.
- State transitions:
  - IDLE → RUN when `en[i]`=1; `cnt`←0 (or the phase value, see Configuration).
  - RUN → STOP when `en[i]`=0.
  - STOP → RUN when `en[i]`=1 again before the boundary. No disturbance to `cnt`.
  - STOP → IDLE at the boundary; `cnt`←0 and `clk_out` stays low.
  - Result: the last period always completes, with no runt pulse.
- Channels are fully independent and share only `clk` and `rst_n`.

## Timing
- Reset: all outputs are 0 immediately on `rst_n` low (asynchronous). All states are IDLE, `cnt`=0, Pa/Ha=2/1, `pend`=0. Release is synchronous to the next `clk` edge.
- Start latency:
  - `en` sampled high at edge t.
  - At t+1: `busy`=1, `cnt`=0, `clk_out`=1, `tick`=1.
- Waveform: `clk_out` is high for Ha cycles and low for Pa-Ha cycles, repeating every Pa cycles. `tick` marks the first high cycle.
- Stop latency: after `en` falls, `clk_out` holds its waveform until the boundary. It is 0 and `busy`=0 from the cycle after the boundary.
- Update latency: a new configuration is visible from the first cycle of the period following the next boundary. It is never applied mid-period.
- Reset mid-period: the output drops low asynchronously. That runt pulse is accepted.

## Configuration
- `CLKGEN_PHASE_EN` defined:
  - The `phase` port exists and is captured with `upd`, in both direct and shadow paths.
  - Capture clamp: phase≥P becomes P-1.
  - On IDLE→RUN, `cnt` loads the phase value, so the first period is shortened to Pa-phase cycles, and `tick` first fires at the first wrap.
  - Phase is ignored on STOP→RUN and on boundary updates.
- Not defined:
  - No `phase` port, no phase storage.
  - `cnt` always starts at 0.

## Test plan
- Reset: hold `rst_n`=0 with `en`=all ones → `clk_out`, `tick`, `pend`, `busy` all 0. Release, then idle `upd` with P=4, H=2 on ch0 and `en[0]`=1 → `clk_out[0]` reads 1100 repeating, `tick[0]` every 4 cycles starting at t+1.
- Clamping: ch1 P=1, H=0 → 2-cycle period, 50% duty. Ch2 P=5, H=9 → high 4, low 1.
- Shadow update: ch0 running P=4/H=2; `upd` P=6/H=1 at `cnt`=1 → `pend`=1 until the boundary, the current period stays 4 cycles, then 100000 repeating, then `pend`=0. A second `upd` before the boundary replaces the shadow.
- Glitch-free stop: drop `en[0]` at `cnt`=0 of P=8/H=4 → 4 high + 4 low cycles complete, then `busy`=0. Re-raise `en` during STOP → continuous waveform with no gap.
- Independence: ch0–ch3 with P=2, 3, 7, 16 running simultaneously → each period exact over 100 cycles, and `tick` counts match 100/P.
- Phase (`CLKGEN_PHASE_EN`): P=8, H=4, phase=6 → first 2 cycles low, then `tick` and normal 8-cycle waveform. Without the macro: phase port absent and start at `cnt`=0.

Source files
------------

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel programmable clock divider with shadowed configuration
// Optional start offset per channel is enabled by defining CLKGEN_PHASE_EN.
module clk_div_gen #(
    parameter int CH = 4,
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    en,
    input  logic [CH-1:0]    upd,
    input  logic [CH*CW-1:0] period,
    input  logic [CH*CW-1:0] high,
`ifdef CLKGEN_PHASE_EN
    input  logic [CH*CW-1:0] phase,
`endif
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    pend,
    output logic [CH-1:0]    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TWO = CW'(2);

    function automatic logic [CW-1:0] clamp_p(input logic [CW-1:0] p);
        logic [CW-1:0] r;
        r = (p < TWO) ? TWO : p;
        return r;
    endfunction

    // p must already be clamped, so the result is always in 1..p-1
    function automatic logic [CW-1:0] clamp_h(input logic [CW-1:0] h, input logic [CW-1:0] p);
        logic [CW-1:0] r;
        if (h == '0)
            r = ONE;
        else if (h >= p)
            r = p - ONE;
        else
            r = h;
        return r;
    endfunction

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t        st_q, st_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [CW-1:0] pa_q, pa_d, ha_q, ha_d;
        logic [CW-1:0] ps_q, ps_d, hs_q, hs_d;
        logic          pend_q, pend_d;
        logic [CW-1:0] p_c, h_c;
        logic [CW-1:0] start_cnt;
        logic          bnd;
        logic          clk_q, clk_d;
        logic          tick_q, tick_d;
        logic          busy_q, busy_d;

        assign p_c = clamp_p(period[i*CW +: CW]);
        assign h_c = clamp_h(high[i*CW +: CW], p_c);
        assign bnd = (st_q != IDLE) && (cnt_q == pa_q - ONE);

`ifdef CLKGEN_PHASE_EN
        logic [CW-1:0] pha_q, pha_d, phs_q, phs_d;
        logic [CW-1:0] ph_c;

        assign ph_c = (phase[i*CW +: CW] >= p_c) ? (p_c - ONE) : phase[i*CW +: CW];

        // the phase only matters at the next IDLE->RUN, so it simply follows the period/high path
        always_comb begin
            pha_d = pha_q;
            phs_d = phs_q;
            if (bnd && pend_q)
                pha_d = phs_q;
            if (upd[i]) begin
                if (st_q == IDLE)
                    pha_d = ph_c;
                else
                    phs_d = ph_c;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pha_q <= '0;
                phs_q <= '0;
            end else begin
                pha_q <= pha_d;
                phs_q <= phs_d;
            end
        end

        assign start_cnt = pha_d;
`else
        assign start_cnt = '0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                pa_q   <= TWO;
                ha_q   <= ONE;
                ps_q   <= TWO;
                hs_q   <= ONE;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                pa_q   <= pa_d;
                ha_q   <= ha_d;
                ps_q   <= ps_d;
                hs_q   <= hs_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
                busy_q <= busy_d;
            end
        end

        // STOP with en high resumes even on the boundary, so a re-raise never leaves a gap
        always_comb begin
            st_d = st_q;
            unique case (st_q)
                IDLE:    if (en[i]) st_d = RUN;
                RUN:     if (!en[i]) st_d = STOP;
                STOP: begin
                    if (en[i])
                        st_d = RUN;
                    else if (bnd)
                        st_d = IDLE;
                end
                default: st_d = IDLE;
            endcase
        end

        // boundary applies the old shadow first, so a coincident upd lands in the shadow and stays pending
        always_comb begin
            pa_d   = pa_q;
            ha_d   = ha_q;
            ps_d   = ps_q;
            hs_d   = hs_q;
            pend_d = pend_q;
            if (bnd && pend_q) begin
                pa_d   = ps_q;
                ha_d   = hs_q;
                pend_d = 1'b0;
            end
            if (upd[i]) begin
                if (st_q == IDLE) begin
                    pa_d = p_c;
                    ha_d = h_c;
                end else begin
                    ps_d   = p_c;
                    hs_d   = h_c;
                    pend_d = 1'b1;
                end
            end
        end

        always_comb begin
            cnt_d = cnt_q;
            if (st_q == IDLE)
                cnt_d = en[i] ? start_cnt : '0;
            else if (bnd)
                cnt_d = '0;
            else
                cnt_d = cnt_q + ONE;
        end

        // outputs are decoded from next-state values and registered, so clk_out is a clean flop
        always_comb begin
            busy_d = (st_d != IDLE);
            clk_d  = busy_d && (cnt_d < ha_d);
            tick_d = busy_d && (cnt_d == '0);
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pend[i]    = pend_q;
        assign busy[i]    = busy_q;
    end

endmodule
